seq_detect_param: RTL and testbench



---
 rtl/seq_detect_param.sv | 148 ++++++++++++++
 tb/tb_seq_detect_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Parametrised serial pattern detector. Watches a qualified serial bit stream
// and raises a registered one-cycle pulse whenever the last N accepted bits
// equal the current pattern (MSB = first bit received). The pattern can be
// replaced at runtime, overlapping matches are selectable at elaboration time,
// and a saturating counter tallies matches.
//
// Parameters
//   N        pattern length in bits (legal range 2..16)
//   PATTERN  pattern loaded at reset, MSB first
//   OVERLAP  1: a match keeps its bits for the next match; 0: history restarts
//   CNT_W    width of the match counter
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   x          serial data bit
//   x_valid    qualifies x; a bit is consumed only when high
//   pat_load   replace the pattern with pat_in and flush the history
//   pat_in     new pattern value (MSB = first bit)
//   clr_cnt    clear the match counter (wins over an increment)
//   z          registered one-cycle match pulse
//   match_cnt  saturating match count
//   armed      history holds N-1 valid bits, so the next bit can complete a match
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int             N       = 3,
    parameter logic [N-1:0]   PATTERN = 3'b101,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             clr_cnt,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    // fill counts 0..N-1; one extra bit is never needed because it saturates.
    localparam int               FILL_W = (N <= 2) ? 1 : $clog2(N);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(N - 1);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // Registered state
    logic [N-1:0]      pattern;
    logic [N-2:0]      history;
    logic [FILL_W-1:0] fill;

    // Next-state / next-output values
    logic [N-1:0]      pattern_next;
    logic [N-2:0]      history_next;
    logic [FILL_W-1:0] fill_next;
    logic              z_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              armed_next;

    // Shared decode
    logic [N-1:0]      candidate;
    logic              accept;
    logic              full;
    logic              hit;

    // The newest bit joins the history at the LSB; the low N-1 bits of this
    // candidate are also the shifted history, which covers N=2 without a
    // special case.
    assign candidate = {history, x};
    assign accept    = x_valid & ~pat_load;
    assign full      = (fill == FULL);
    assign hit       = accept & full & (candidate == pattern);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern   <= PATTERN;
            history   <= '0;
            fill      <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            pattern   <= pattern_next;
            history   <= history_next;
            fill      <= fill_next;
            z         <= z_next;
            match_cnt <= cnt_next;
            armed     <= armed_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: fill is the FSM state (FILL below N-1, ARMED at N-1)
    // -------------------------------------------------------------------------
    always_comb begin
        pattern_next = pattern;
        history_next = history;
        fill_next    = fill;

        if (pat_load) begin
            // A new pattern invalidates any partial match; the bit on x this
            // cycle is dropped.
            pattern_next = pat_in;
            history_next = '0;
            fill_next    = '0;
        end else if (x_valid) begin
            if (hit && !OVERLAP) begin
                // Non-overlapping: the next match needs N fresh bits.
                history_next = '0;
                fill_next    = '0;
            end else begin
                history_next = candidate[N-2:0];
                fill_next    = full ? fill : fill + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: values registered on the same edge as the state
    // -------------------------------------------------------------------------
    always_comb begin
        z_next     = hit;
        armed_next = (fill_next == FULL);

        if (clr_cnt) begin
            cnt_next = '0;
        end else if (hit) begin
            cnt_next = sat_inc(match_cnt);
        end else begin
            cnt_next = match_cnt;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'h0;
    logic       clr_cnt = 1'b0;

    always #5 clk = ~clk;

    // DUT 0: defaults (N=3, 101, overlap, CNT_W=8)
    // DUT 1: non-overlapping
    // DUT 2: CNT_W=2 for saturation
    // DUT 3: N=4, 1011
    logic       z0, z1, z2, z3;
    logic       a0, a1, a2, a3;
    logic [7:0] c0, c1, c3;
    logic [1:0] c2;

    seq_detect_param u_ov (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in[2:0]), .clr_cnt(clr_cnt), .z(z0), .match_cnt(c0), .armed(a0));

    seq_detect_param #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in[2:0]), .clr_cnt(clr_cnt), .z(z1), .match_cnt(c1), .armed(a1));

    seq_detect_param #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in[2:0]), .clr_cnt(clr_cnt), .z(z2), .match_cnt(c2), .armed(a2));

    seq_detect_param #(.N(4), .PATTERN(4'b1011)) u_n4 (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in), .clr_cnt(clr_cnt), .z(z3), .match_cnt(c3), .armed(a3));

    typedef struct {
        int    dut;
        bit    z;
        int    cnt;
        bit    armed;
        string name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: after each edge, every expectation queued for that edge is
    // compared against the addressed DUT's outputs.
    exp_t mon_e;
    bit   act_z;
    int   act_cnt;
    bit   act_armed;

    always begin
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            case (mon_e.dut)
                0:       begin act_z = z0; act_cnt = int'(c0); act_armed = a0; end
                1:       begin act_z = z1; act_cnt = int'(c1); act_armed = a1; end
                2:       begin act_z = z2; act_cnt = int'(c2); act_armed = a2; end
                default: begin act_z = z3; act_cnt = int'(c3); act_armed = a3; end
            endcase
            checks++;
            if (act_z !== mon_e.z || act_cnt != mon_e.cnt || act_armed !== mon_e.armed) begin
                errors++;
                $display("FAIL %s dut%0d: got z=%0b cnt=%0d armed=%0b, want z=%0b cnt=%0d armed=%0b",
                         mon_e.name, mon_e.dut, act_z, act_cnt, act_armed,
                         mon_e.z, mon_e.cnt, mon_e.armed);
            end
        end
    end

    // Inputs change mid-cycle, well clear of both edges and the monitor sample.
    task automatic drive(input bit r, input bit xb, input bit v, input bit ld,
                         input logic [3:0] pin, input bit clr);
        @(posedge clk);
        #3;
        reset    = r;
        x        = xb;
        x_valid  = v;
        pat_load = ld;
        pat_in   = pin;
        clr_cnt  = clr;
    endtask

    task automatic expect_out(input int d, input bit ez, input int ec, input bit ea,
                              input string nm);
        exp_t e;
        e.dut = d; e.z = ez; e.cnt = ec; e.armed = ea; e.name = nm;
        q.push_back(e);
    endtask

    task automatic bit_in(input bit xb);
        drive(1'b0, xb, 1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        for (int d = 0; d < 4; d++) expect_out(d, 1'b0, 0, 1'b0, "reset");
    endtask

    // Stream 1,1,0,1,0,1,1 (index 0 = first bit)
    localparam logic [6:0] S1     = 7'b1101011;
    localparam logic [6:0] S1_OVZ = 7'b0001010;
    localparam logic [6:0] S1_OVA = 7'b0111111;
    localparam logic [6:0] S1_NOZ = 7'b0001000;
    localparam logic [6:0] S1_NOA = 7'b0110011;
    int s1_ovc [7] = '{0, 0, 0, 1, 1, 2, 2};
    int s1_noc [7] = '{0, 0, 0, 1, 1, 1, 1};

    // Stream 1,0,1,0,1
    localparam logic [4:0] S2     = 5'b10101;
    localparam logic [4:0] S2_OVZ = 5'b00101;
    localparam logic [4:0] S2_OVA = 5'b01111;
    localparam logic [4:0] S2_NOZ = 5'b00100;
    localparam logic [4:0] S2_NOA = 5'b01001;
    int s2_ovc [5] = '{0, 0, 1, 1, 2};
    int s2_noc [5] = '{0, 0, 1, 1, 1};

    // Gapped 1,0,1 with three idle cycles between bits, then one idle
    localparam logic [9:0] S3_X = 10'b1111011110;
    localparam logic [9:0] S3_V = 10'b1000100010;
    localparam logic [9:0] S3_Z = 10'b0000000010;
    localparam logic [9:0] S3_A = 10'b0000111111;

    // N=4 stream 1,0,1,1,0,1,1
    localparam logic [6:0] S4     = 7'b1011011;
    localparam logic [6:0] S4_Z   = 7'b0001001;
    localparam logic [6:0] S4_A   = 7'b0011111;
    int s4_c [7] = '{0, 0, 0, 1, 1, 1, 2};

    int  c0e;
    int  c2e;
    bit  hit;

    initial begin
        // Overlap vs non-overlap, stream 1101011
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bit_in(S1[6-i]);
            expect_out(0, S1_OVZ[6-i], s1_ovc[i], S1_OVA[6-i], "ovl_s1");
            expect_out(1, S1_NOZ[6-i], s1_noc[i], S1_NOA[6-i], "novl_s1");
        end

        // Stream 10101
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bit_in(S2[4-i]);
            expect_out(0, S2_OVZ[4-i], s2_ovc[i], S2_OVA[4-i], "ovl_s2");
            expect_out(1, S2_NOZ[4-i], s2_noc[i], S2_NOA[4-i], "novl_s2");
        end

        // x_valid gaps; x is held at 1 while idle and must be ignored
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, S3_X[9-i], S3_V[9-i], 1'b0, 4'h0, 1'b0);
            expect_out(0, S3_Z[9-i], (i >= 8) ? 1 : 0, S3_A[9-i], "gaps");
        end

        // Runtime pattern load over a pending partial match
        do_reset();
        bit_in(1'b1); expect_out(0, 1'b0, 0, 1'b0, "pre_load_b1");
        bit_in(1'b0); expect_out(0, 1'b0, 0, 1'b1, "pre_load_b2");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        expect_out(0, 1'b0, 0, 1'b0, "load_flush");
        bit_in(1'b1); expect_out(0, 1'b0, 0, 1'b0, "new_pat_b1");
        bit_in(1'b0); expect_out(0, 1'b0, 0, 1'b1, "new_pat_b2");
        bit_in(1'b1); expect_out(0, 1'b0, 0, 1'b1, "old_pat_ignored");
        bit_in(1'b1); expect_out(0, 1'b0, 0, 1'b1, "new_pat_b4");
        bit_in(1'b1); expect_out(0, 1'b0, 0, 1'b1, "new_pat_b5");
        bit_in(1'b0); expect_out(0, 1'b1, 1, 1'b1, "new_pat_match");
        // Reset restores the default pattern
        do_reset();
        bit_in(1'b1); expect_out(0, 1'b0, 0, 1'b0, "revert_b1");
        bit_in(1'b0); expect_out(0, 1'b0, 0, 1'b1, "revert_b2");
        bit_in(1'b1); expect_out(0, 1'b1, 1, 1'b1, "revert_match");

        // Saturation (CNT_W=2) and clear-with-match
        do_reset();
        c0e = 0;
        c2e = 0;
        for (int i = 1; i <= 21; i++) begin
            drive(1'b0, (i % 2) == 1, 1'b1, 1'b0, 4'h0, i == 19);
            hit = (i >= 3) && ((i % 2) == 1);
            if (hit) c0e++;
            if (i == 19)      c2e = 0;
            else if (hit)     c2e = (c2e < 3) ? c2e + 1 : 3;
            expect_out(2, hit, c2e, i >= 2, "sat");
            if (i == 17) expect_out(0, 1'b1, 8, 1'b1, "wide_cnt_8");
        end

        // N=4, pattern 1011
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bit_in(S4[6-i]);
            expect_out(3, S4_Z[6-i], s4_c[i], S4_A[6-i], "n4_s4");
        end
        bit_in(1'b1); expect_out(3, 1'b0, 2, 1'b1, "n4_pre_b1");
        bit_in(1'b0); expect_out(3, 1'b0, 2, 1'b1, "n4_pre_b2");
        bit_in(1'b1); expect_out(3, 1'b0, 2, 1'b1, "n4_pre_b3");
        do_reset();
        bit_in(1'b1); expect_out(3, 1'b0, 0, 1'b0, "n4_post_b1");
        bit_in(1'b0); expect_out(3, 1'b0, 0, 1'b0, "n4_post_b2");
        bit_in(1'b1); expect_out(3, 1'b0, 0, 1'b1, "n4_post_b3");
        bit_in(1'b1); expect_out(3, 1'b1, 1, 1'b1, "n4_post_match");

        // Idle, then drain the scoreboard with a bounded wait
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule
